// File: rtl/pfiform_pkg.sv
// Shared defaults and derived widths for the pfiform unit-granular gearbox FIFO.
// Optional PFIFORM_ERR_EN adds a sticky join-drop error flag on the top level.
package pfiform_pkg;
    localparam int UNIT_W_DEF = 6;
    localparam int LANES_DEF  = 16;
    localparam int DEPTH_DEF  = 64;
    localparam int WORD_W     = UNIT_W_DEF * LANES_DEF;
    localparam int AMT_W      = $clog2(LANES_DEF);
    localparam int PTR_W      = $clog2(DEPTH_DEF);
    localparam int CNT_W      = $clog2(DEPTH_DEF + 1);
endpackage

// File: rtl/pfiform_ring.sv
// DEPTH x UNIT_W circular buffer: writes lanes 0..wr_amt at wr_ptr, reads LANES units from rd_ptr.
// Contents are never reset; the control logic decides which units are valid.
module pfiform_ring
    import pfiform_pkg::*;
#(
    parameter int UNIT_W = UNIT_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [$clog2(LANES)-1:0]   wr_amt,
    input  logic [UNIT_W*LANES-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [UNIT_W*LANES-1:0]    rd_data
);
    localparam int P_W = $clog2(DEPTH);

    logic [UNIT_W-1:0] mem [DEPTH];

    // Address arithmetic is P_W bits wide so it wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (k <= int'(wr_amt))
                    mem[wr_ptr + P_W'(k)] <= wr_data[k*UNIT_W +: UNIT_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < LANES; k++)
            rd_data[k*UNIT_W +: UNIT_W] = mem[rd_ptr + P_W'(k)];
    end
endmodule

// File: rtl/pfiform.sv
// pfiform: gearbox FIFO turning joins of JoinAmout+1 units into pops of PopAmout+1 units.
// Define PFIFORM_ERR_EN to add the sticky o_join_drop_err output.
module pfiform
    import pfiform_pkg::*;
#(
    parameter int UNIT_W = UNIT_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       i_core_clk,
    input  logic                       i_rx_rstn,
    input  logic                       JoinEnable,
    output logic                       JoinPermit,
    input  logic [$clog2(LANES)-1:0]   JoinAmout,
    input  logic [UNIT_W*LANES-1:0]    JoinData,
    input  logic                       PopPermit,
    input  logic [$clog2(LANES)-1:0]   PopAmout,
    output logic                       PopEnable,
    output logic [UNIT_W*LANES-1:0]    PopData
`ifdef PFIFORM_ERR_EN
    ,
    output logic                       o_join_drop_err
`endif
);
    localparam int P_W = $clog2(DEPTH);
    localparam int C_W = $clog2(DEPTH + 1);
    localparam int W_W = UNIT_W * LANES;

    logic [P_W-1:0] wr_ptr, rd_ptr;
    logic [C_W-1:0] count, join_units, pop_units, free_units;
    logic           join_fire, pop_fire;
    logic [W_W-1:0] rd_word;

    // Handshakes: a join moves when JoinEnable && JoinPermit, a pop when PopEnable && PopPermit.
    // Both decisions use registered count only, so a joined unit is poppable the next cycle.
    always_comb begin
        join_units = C_W'(JoinAmout) + C_W'(1);
        pop_units  = C_W'(PopAmout) + C_W'(1);
        free_units = C_W'(DEPTH) - count;
        JoinPermit = !i_rx_rstn && (free_units >= join_units);
        PopEnable  = (count >= pop_units);
        join_fire  = JoinEnable && JoinPermit;
        pop_fire   = PopEnable && PopPermit;
        PopData    = '0;
        for (int k = 0; k < LANES; k++) begin
            if (PopEnable && k <= int'(PopAmout))
                PopData[k*UNIT_W +: UNIT_W] = rd_word[k*UNIT_W +: UNIT_W];
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (join_fire)
                wr_ptr <= wr_ptr + P_W'(join_units);
            if (pop_fire)
                rd_ptr <= rd_ptr + P_W'(pop_units);
            count <= count + (join_fire ? join_units : '0) - (pop_fire ? pop_units : '0);
        end
    end

`ifdef PFIFORM_ERR_EN
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rstn)
            o_join_drop_err <= 1'b0;
        else if (JoinEnable && !JoinPermit)
            o_join_drop_err <= 1'b1;
    end
`endif

    pfiform_ring #(
        .UNIT_W (UNIT_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk     (i_core_clk),
        .wr_en   (join_fire),
        .wr_ptr  (wr_ptr),
        .wr_amt  (JoinAmout),
        .wr_data (JoinData),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_word)
    );
endmodule

// File: tb/tb_pfiform.sv
// Bench for pfiform: directed steps plus random traffic against a unit-queue reference model.
// Define PFIFORM_ERR_EN to also exercise the sticky join-drop flag.
module tb_pfiform;
  import pfiform_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        je = 1'b0;
  logic        pp = 1'b0;
  logic [3:0]  ja = '0;
  logic [3:0]  pa = '0;
  logic [95:0] jd = '0;
  logic        jp, pe;
  logic [95:0] pd;
`ifdef PFIFORM_ERR_EN
  logic        drop_err;
  logic        err_m = 1'b0;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [5:0]  model_q[$];
  logic [5:0]  next_unit;
  logic        acc;
  logic [95:0] w;

  always #5 clk = ~clk;

  pfiform dut (
    .i_core_clk (clk),
    .i_rx_rstn  (rst),
    .JoinEnable (je),
    .JoinPermit (jp),
    .JoinAmout  (ja),
    .JoinData   (jd),
    .PopPermit  (pp),
    .PopAmout   (pa),
    .PopEnable  (pe),
    .PopData    (pd)
`ifdef PFIFORM_ERR_EN
    ,
    .o_join_drop_err (drop_err)
`endif
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] make_word(input int start, input int n);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*UNIT_W_DEF +: UNIT_W_DEF] = 6'(start + k);
    return r;
  endfunction

  function automatic logic [95:0] model_word(input int n);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*UNIT_W_DEF +: UNIT_W_DEF] = model_q[k];
    return r;
  endfunction

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic je_i, input logic [3:0] ja_i, input logic [95:0] jd_i,
                       input logic pp_i, input logic [3:0] pa_i, output logic acc_o);
    logic exp_jp, exp_pe;
    je = je_i; ja = ja_i; jd = jd_i; pp = pp_i; pa = pa_i;
    #1;
    exp_jp = !rst && (DEPTH_DEF - model_q.size() >= int'(ja_i) + 1);
    exp_pe = model_q.size() >= int'(pa_i) + 1;
    check("join_permit", 96'(jp), 96'(exp_jp));
    check("pop_enable", 96'(pe), 96'(exp_pe));
    check("pop_data", pd, exp_pe ? model_word(int'(pa_i) + 1) : 96'(0));
`ifdef PFIFORM_ERR_EN
    check("drop_err", 96'(drop_err), 96'(err_m));
`endif
    acc_o = je_i && exp_jp;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
`ifdef PFIFORM_ERR_EN
      err_m = 1'b0;
`endif
    end else begin
      if (exp_pe && pp_i)
        for (int k = 0; k <= int'(pa_i); k++) void'(model_q.pop_front());
      if (acc_o)
        for (int k = 0; k <= int'(ja_i); k++) model_q.push_back(jd_i[k*UNIT_W_DEF +: UNIT_W_DEF]);
`ifdef PFIFORM_ERR_EN
      if (je_i && !exp_jp) err_m = 1'b1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic a;
    rst = 1'b1;
    cycle(1'b0, 4'd0, '0, 1'b0, 4'd0, a);
    cycle(1'b0, 4'd0, '0, 1'b0, 4'd0, a);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Streaming 16-unit joins into 12-unit pops.
    next_unit = '0;
    cycle(1'b1, 4'd15, make_word(int'(next_unit), 16), 1'b1, 4'd11, acc);
    if (acc) next_unit += 6'd16;
    #1;
    check("first_pop_en", 96'(pe), 96'(1'b1));
    check("first_pop_data", pd, make_word(0, 12));
    cycle(1'b1, 4'd15, make_word(int'(next_unit), 16), 1'b1, 4'd11, acc);
    if (acc) next_unit += 6'd16;
    #1;
    check("second_pop_data", pd, make_word(12, 12));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'd15, make_word(int'(next_unit), 16), 1'b1, 4'd11, acc);
      if (acc) next_unit += 6'd16;
    end

    // Backpressure: consumer stalled, buffer fills after four joins.
    do_reset();
    next_unit = '0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'd15, make_word(int'(next_unit), 16), 1'b0, 4'd11, acc);
      if (acc) next_unit += 6'd16;
    end
    #1;
    check("full_join_permit", 96'(jp), 96'(1'b0));
    check("full_pop_data", pd, make_word(0, 12));

    // Partial join: only lanes 0..2 count, upper lanes are garbage.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      w = {$urandom(), $urandom(), $urandom()};
      w[0 +: 6] = 6'd7; w[6 +: 6] = 6'd8; w[12 +: 6] = 6'd9;
      cycle(1'b1, 4'd2, w, 1'b0, 4'd5, acc);
    end
    #1;
    w = '0;
    for (int k = 0; k < 6; k++) w[k*6 +: 6] = 6'(7 + k % 3);
    check("partial_pop_data", pd, w);
    cycle(1'b0, 4'd2, '0, 1'b1, 4'd5, acc);
    cycle(1'b0, 4'd2, '0, 1'b1, 4'd5, acc);

    // Long run across many pointer wraps with random consumer stalls.
    do_reset();
    next_unit = '0;
    for (int i = 0; i < 1200; i++) begin
      cycle(1'b1, 4'd15, make_word(int'(next_unit), 16), 1'($urandom_range(0, 1)), 4'd11, acc);
      if (acc) next_unit += 6'd16;
    end

    // Fully random amounts, data and handshakes.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            {$urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), acc);
    end

    // Reset in the middle of a stream holding 40 units.
    do_reset();
    cycle(1'b1, 4'd15, make_word(0, 16), 1'b0, 4'd11, acc);
    cycle(1'b1, 4'd15, make_word(16, 16), 1'b0, 4'd11, acc);
    cycle(1'b1, 4'd7, make_word(32, 16), 1'b0, 4'd11, acc);
    rst = 1'b1;
    cycle(1'b0, 4'd0, '0, 1'b0, 4'd11, acc);
    #1;
    check("mid_rst_pop_en", 96'(pe), 96'(1'b0));
    check("mid_rst_pop_data", pd, 96'(0));
    check("mid_rst_join_permit", 96'(jp), 96'(1'b0));
    rst = 1'b0;
    cycle(1'b1, 4'd3, make_word(50, 16), 1'b0, 4'd0, acc);
    #1;
    check("post_rst_first_unit", pd, make_word(50, 1));
    cycle(1'b0, 4'd3, '0, 1'b1, 4'd0, acc);

`ifdef PFIFORM_ERR_EN
    // Join offered while full sets the sticky drop flag until reset.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd15, make_word(16 * i, 16), 1'b0, 4'd11, acc);
    cycle(1'b1, 4'd15, make_word(0, 16), 1'b0, 4'd11, acc);
    #1;
    check("drop_err_set", 96'(drop_err), 96'(1'b1));
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, '0, 1'b1, 4'd11, acc);
    #1;
    check("drop_err_sticky", 96'(drop_err), 96'(1'b1));
    do_reset();
    #1;
    check("drop_err_cleared", 96'(drop_err), 96'(1'b0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pfiform.md
PFIFORM -- requirements
Module: pfiform

Interface
REQ-001 SHALL have parameter UNIT_W, default 6, the width in bits of one data unit.
REQ-002 SHALL have parameter LANES, default 16, the number of unit lanes per data word (word = UNIT_W*LANES = 96 bits).
REQ-003 SHALL have parameter DEPTH, default 64, the buffer capacity in units; it SHALL be a power of two and at least 2*LANES.
REQ-004 SHALL have port i_core_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rx_rstn, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port JoinEnable, input, 1 bit: the producer offers JoinData this cycle.
REQ-007 SHALL have port JoinPermit, output, 1 bit: the block can accept a join this cycle.
REQ-008 SHALL have port JoinAmout, input, 4 bits: units offered minus one (0..15 means 1..16 units).
REQ-009 SHALL have port JoinData, input, 96 bits: lane k occupies bits [6k+5:6k], and lane 0 is the oldest.
REQ-010 SHALL have port PopPermit, input, 1 bit: the consumer accepts PopData this cycle.
REQ-011 SHALL have port PopAmout, input, 4 bits: units per pop minus one.
REQ-012 SHALL have port PopEnable, output, 1 bit: PopData is valid.
REQ-013 SHALL have port PopData, output, 96 bits: the popped units, lane 0 = oldest.

Function
REQ-014 SHALL act as a unit-granular FIFO (gearbox) that converts join groups of JoinAmout+1 units into pop groups of PopAmout+1 units, preserving unit order.
REQ-015 SHALL assert JoinPermit if and only if the free space before this cycle's pop, DEPTH-count, is at least JoinAmout+1.
REQ-016 SHALL perform a join only when JoinEnable and JoinPermit are both high; it appends lanes 0..JoinAmout at the write pointer, and the upper lanes are ignored.
REQ-017 SHALL drop a JoinEnable that arrives while JoinPermit is low, with no state change.
REQ-018 SHALL assert PopEnable if and only if count is at least PopAmout+1, evaluated from registered state only.
REQ-019 SHALL drive PopData combinationally from registered state: lanes 0..PopAmout carry the oldest units, and all higher lanes are 0; when PopEnable is low, PopData is 0.
REQ-020 SHALL perform a pop when PopEnable and PopPermit are both high, advancing the read pointer by PopAmout+1.
REQ-021 SHALL make a joined unit visible to a pop no earlier than the next cycle, giving a minimum latency of 1 cycle.
REQ-022 SHALL allow a join and a pop in the same cycle, with next count = count + joined - popped.
REQ-023 SHALL make pointers wrap modulo DEPTH and SHALL keep count in 0..DEPTH; overflow and underflow are impossible by construction.
REQ-024 SHALL sample JoinAmout and PopAmout every cycle and apply them only to that cycle's transfer, so they may change between transfers.

Reset
REQ-025 SHALL, while i_rx_rstn is high at a clock edge, clear the pointers and count to 0, drive JoinPermit to 0, and drive PopEnable to 0 and PopData to 0.
REQ-026 SHALL raise JoinPermit in the first cycle after reset deassertion.
REQ-027 SHALL, on a reset mid-operation, discard all buffered units; buffer contents need not be cleared.

Configuration
REQ-028 SHALL, with macro PFIFORM_ERR_EN defined, add an output o_join_drop_err (1 bit) that is a sticky flag set when JoinEnable is high and JoinPermit is low, and cleared only by reset.
REQ-029 SHALL, without PFIFORM_ERR_EN, omit the port o_join_drop_err and its logic.

Structure
REQ-030 SHALL place UNIT_W, LANES, DEPTH defaults, the word width and the pointer/count width localparams in package pfiform_pkg.
REQ-031 SHALL use sub-module pfiform_ring, a DEPTH x UNIT_W circular buffer with a multi-unit write port and a multi-unit read port; the top level holds the control and handshake logic.

Verification
REQ-032 SHALL verify the default case: reset, then JoinAmout=15, PopAmout=11, PopPermit=1, JoinEnable=1, and each word has lanes m..m+15, with m stepping by 16 mod 64. The first PopEnable SHALL occur 1 cycle after the first join, with PopData lanes 0..11 = 0..11 and lanes 12..15 = 0. The next pop SHALL be 12,13,14,15,16..23, with the unit sequence continuous and no gaps.
REQ-033 SHALL verify backpressure: PopPermit=0 with continuous joins of 16 units. JoinPermit SHALL fall after 4 joins (count 64), and PopData SHALL remain stable at the oldest units.
REQ-034 SHALL verify partial join: JoinAmout=2 with lanes 7,8,9 and garbage in lanes 3..15, and PopAmout=5. After 2 joins PopData lanes 0..5 SHALL be 7,8,9,7,8,9.
REQ-035 SHALL verify wrap-around: 1000+ cycles of JoinAmout=15 with PopAmout=11 and random PopPermit. The unit order SHALL be preserved across pointer wraps.
REQ-036 SHALL verify reset mid-stream: assert i_rx_rstn with count 40. The next cycle SHALL show PopEnable=0, PopData=0 and JoinPermit=0, and after release the first popped unit SHALL come from the first post-reset join.
REQ-037 SHALL, with PFIFORM_ERR_EN, verify join drop: JoinEnable=1 while full. o_join_drop_err SHALL rise next cycle and stay 1 until reset.
